// File: rtl/spi_burst_controller.sv
// spi_burst_controller: multi-lane SPI burst master with byte-wide TX/RX FIFOs
module spi_burst_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic [AW:0]   count
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign rd_data = mem[rd_ptr];
   // pointers wrap naturally at DEPTH; occupancy tracks push minus pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
   end
   // byte storage
   always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= wr_data;
endmodule

module spi_burst_controller #(
   parameter int FIFO_DEPTH = 16,
   parameter int NUM_CS = 2,
   parameter int LEN_WIDTH = 12,
   parameter int DIV_WIDTH = 8,
   localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1,
   localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] xfer_len,
   input  logic [CSW-1:0]       xfer_cs,
   input  logic [2:0]           xfer_mode,
   input  logic                 xfer_dir,
   input  logic [DIV_WIDTH-1:0] clk_div,
   input  logic [7:0]           tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 spi_clk,
   output logic [NUM_CS-1:0]    spi_cs_n,
   input  logic [3:0]           spi_data_in,
   output logic [3:0]           spi_data_out,
   output logic [3:0]           spi_data_oe
);
   typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, SHIFT_LO, SHIFT_HI, CS_HOLD} state_t;
   state_t state, state_nx;
   logic [LEN_WIDTH-1:0] len_q;
   logic [DIV_WIDTH-1:0] div_q, cnt;
   logic                 quad_q, dual_q, dir_q;
   logic [2:0]           sck_left;
   logic [7:0]           tx_sh, rx_sh, tx_head, tx_src;
   logic [CW-1:0]        tx_count, rx_count;
   logic tx_need, rx_need, phase_end, room, room_chain, tx_pop, rx_push;
   logic load, advance, rise, fall, byte_end, release_cs;
   assign busy      = state != IDLE;
   assign tx_ready  = tx_count != CW'(FIFO_DEPTH);
   assign rx_valid  = rx_count != '0;
   assign tx_need   = (!quad_q && !dual_q) || dir_q;
   assign rx_need   = (!quad_q && !dual_q) || !dir_q;
   assign phase_end = cnt == div_q;
   assign room       = (!tx_need || tx_count != '0) && (!rx_need || rx_count < CW'(FIFO_DEPTH));
   assign room_chain = (!tx_need || tx_count != '0) && (!rx_need || rx_count < CW'(FIFO_DEPTH - 1));
   assign tx_pop    = load && tx_need;
   assign tx_src    = load ? (tx_need ? tx_head : 8'h00) : tx_sh;

   spi_burst_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
      .clk(clk), .reset_n(reset_n), .wr_en(tx_valid && tx_ready), .wr_data(tx_data),
      .rd_en(tx_pop), .rd_data(tx_head), .count(tx_count)
   );
   spi_burst_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
      .clk(clk), .reset_n(reset_n), .wr_en(rx_push), .wr_data(rx_sh),
      .rd_en(rx_ready && rx_valid), .rd_data(rx_data), .count(rx_count)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // next state and per-cycle control strobes; a byte boundary with data ready skips LOAD
   always_comb begin
      state_nx   = state;
      load       = 1'b0;
      rx_push    = 1'b0;
      rise       = state == SHIFT_LO && phase_end;
      fall       = state == SHIFT_HI && phase_end;
      byte_end   = fall && sck_left == 3'd0;
      advance    = fall && sck_left != 3'd0;
      release_cs = state == CS_HOLD && phase_end;
      case (state)
         IDLE:     if (start) state_nx = CS_SETUP;
         CS_SETUP: if (phase_end) state_nx = LOAD;
         LOAD:     if (room) begin
                      load     = 1'b1;
                      state_nx = SHIFT_LO;
                   end
         SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
         SHIFT_HI: if (phase_end) begin
                      rx_push = byte_end && rx_need;
                      if (!byte_end) state_nx = SHIFT_LO;
                      else if (len_q == '0) state_nx = CS_HOLD;
                      else if (room_chain) begin
                         load     = 1'b1;
                         state_nx = SHIFT_LO;
                      end else state_nx = LOAD;
                   end
         CS_HOLD:  if (phase_end) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // burst datapath: latched command, phase timer, shifters and pin registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q        <= '0;
         div_q        <= '0;
         quad_q       <= 1'b0;
         dual_q       <= 1'b0;
         dir_q        <= 1'b0;
         cnt          <= '0;
         sck_left     <= '0;
         tx_sh        <= '0;
         rx_sh        <= '0;
         spi_clk      <= 1'b0;
         spi_cs_n     <= '1;
         spi_data_out <= '0;
         spi_data_oe  <= '0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= state_nx != state ? '0 : cnt + 1'b1;
         if (state == IDLE && start) begin
            len_q       <= xfer_len;
            div_q       <= clk_div;
            quad_q      <= xfer_mode == 3'b100;
            dual_q      <= xfer_mode == 3'b010;
            dir_q       <= xfer_dir;
            spi_cs_n    <= ~(NUM_CS'(1) << xfer_cs);
            spi_data_oe <= xfer_mode == 3'b100 ? {4{xfer_dir}} :
                           xfer_mode == 3'b010 ? {2'b00, {2{xfer_dir}}} : 4'b0001;
         end
         if (load || advance) begin
            spi_data_out <= quad_q ? tx_src[7:4] : dual_q ? {2'b00, tx_src[7:6]} : {3'b000, tx_src[7]};
            tx_sh        <= quad_q ? {tx_src[3:0], 4'h0} : dual_q ? {tx_src[5:0], 2'b00} : {tx_src[6:0], 1'b0};
            sck_left     <= load ? (quad_q ? 3'd1 : dual_q ? 3'd3 : 3'd7) : sck_left - 3'd1;
         end
         if (rise) begin
            spi_clk <= 1'b1;
            rx_sh   <= quad_q ? {rx_sh[3:0], spi_data_in} :
                       dual_q ? {rx_sh[5:0], spi_data_in[1:0]} : {rx_sh[6:0], spi_data_in[1]};
         end
         if (fall) spi_clk <= 1'b0;
         if (byte_end && len_q != '0) len_q <= len_q - 1'b1;
         if (release_cs) begin
            spi_cs_n     <= '1;
            spi_data_oe  <= '0;
            spi_data_out <= '0;
            done         <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_spi_burst_controller.sv
// tb_spi_burst_controller: directed checks of bursts, lane modes, stalls and reset
module tb_spi_burst_controller;
   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [11:0] xfer_len = '0;
   logic        xfer_cs = 1'b0, xfer_dir = 1'b0;
   logic [2:0]  xfer_mode = 3'b001;
   logic [7:0]  clk_div = '0, tx_data = '0, rx_data;
   logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
   logic        busy, done, spi_clk;
   logic [1:0]  spi_cs_n;
   logic [3:0]  spi_data_in, spi_data_out, spi_data_oe;
   int          total = 0, bad = 0, sck_cnt = 0, done_cnt = 0, sbase = 0, base, dbase, n;
   logic        loop_en = 1'b1;
   logic [3:0]  slave_tbl [4];
   time         rise_t [64];
   logic [3:0]  out_log [64];
   logic [3:0]  oe_log [64];
   logic [1:0]  cs_log [64];

   spi_burst_controller #(.FIFO_DEPTH(4), .NUM_CS(2), .LEN_WIDTH(12), .DIV_WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .xfer_len(xfer_len), .xfer_cs(xfer_cs),
      .xfer_mode(xfer_mode), .xfer_dir(xfer_dir), .clk_div(clk_div), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .busy(busy), .done(done), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
      .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe)
   );

   always #5 clk = ~clk;

   assign spi_data_in = loop_en ? {2'b00, spi_data_out[0], 1'b0} : slave_tbl[2'(sck_cnt - sbase)];

   always @(posedge spi_clk) begin
      rise_t[sck_cnt[5:0]]  <= $time;
      out_log[sck_cnt[5:0]] <= spi_data_out;
      oe_log[sck_cnt[5:0]]  <= spi_data_oe;
      cs_log[sck_cnt[5:0]]  <= spi_cs_n;
      sck_cnt <= sck_cnt + 1;
   end

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   function automatic logic [5:0] ix(input int k);
      return 6'(k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic burst(input int len, input int cs, input logic [2:0] mode, input logic dir, input int div);
      @(negedge clk);
      xfer_len  = 12'(len);
      xfer_cs   = 1'(cs);
      xfer_mode = mode;
      xfer_dir  = dir;
      clk_div   = 8'(div);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int b = done_cnt;
      for (int i = 0; i < max && done_cnt == b; i++) @(negedge clk);
      check(tag, done_cnt - b, 1);
   endtask

   task automatic pop_rx(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, rx_valid, 1);
      check(tag, rx_data, exp);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_sck", spi_clk, 0);
      check("rst_cs", spi_cs_n, 2'b11);
      check("rst_dout", spi_data_out, 0);
      check("rst_oe", spi_data_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      reset_n = 1'b1;

      // single lane, loopback IO1 <= IO0
      loop_en = 1'b1;
      push_tx(8'hA5);
      push_tx(8'h3C);
      base  = sck_cnt;
      dbase = done_cnt;
      burst(1, 0, 3'b001, 1'b0, 0);
      check("single_busy", busy, 1);
      wait_done("single_done", 200);
      check("single_sck", sck_cnt - base, 16);
      check("single_span", 32'(rise_t[ix(base + 15)] - rise_t[ix(base)]), 300);
      check("single_cs_first", cs_log[ix(base)], 2'b10);
      check("single_cs_last", cs_log[ix(base + 15)], 2'b10);
      check("single_oe", oe_log[ix(base)], 4'b0001);
      repeat (5) @(negedge clk);
      check("single_done_once", done_cnt - dbase, 1);
      check("single_idle_cs", spi_cs_n, 2'b11);
      pop_rx("single_rx0", 8'hA5);
      pop_rx("single_rx1", 8'h3C);
      check("single_rx_empty", rx_valid, 0);

      // quad write
      loop_en = 1'b0;
      push_tx(8'h12);
      push_tx(8'h34);
      base = sck_cnt;
      burst(1, 0, 3'b100, 1'b1, 2);
      wait_done("quad_done", 300);
      check("quad_sck", sck_cnt - base, 4);
      check("quad_nib0", out_log[ix(base)], 4'h1);
      check("quad_nib1", out_log[ix(base + 1)], 4'h2);
      check("quad_nib2", out_log[ix(base + 2)], 4'h3);
      check("quad_nib3", out_log[ix(base + 3)], 4'h4);
      check("quad_oe", oe_log[ix(base + 2)], 4'hF);
      check("quad_span", 32'(rise_t[ix(base + 3)] - rise_t[ix(base)]), 180);
      check("quad_no_rx", rx_valid, 0);
      check("quad_oe_idle", spi_data_oe, 4'h0);

      // dual read with TX FIFO full, which must stay untouched
      push_tx(8'h11);
      push_tx(8'h22);
      push_tx(8'h33);
      push_tx(8'h44);
      check("dual_tx_full", tx_ready, 0);
      slave_tbl[0] = 4'b0010;
      slave_tbl[1] = 4'b0001;
      slave_tbl[2] = 4'b0011;
      slave_tbl[3] = 4'b0000;
      base  = sck_cnt;
      sbase = sck_cnt;
      burst(0, 1, 3'b010, 1'b0, 1);
      wait_done("dual_done", 200);
      check("dual_sck", sck_cnt - base, 4);
      check("dual_oe", oe_log[ix(base)], 4'h0);
      check("dual_cs", cs_log[ix(base)], 2'b01);
      check("dual_tx_kept", tx_ready, 0);
      pop_rx("dual_rx", 8'h9C);
      check("dual_rx_empty", rx_valid, 0);

      // reset in the middle of a quad read burst
      for (int i = 0; i < 4; i++) slave_tbl[i] = 4'h5;
      burst(15, 0, 3'b100, 1'b0, 0);
      repeat (30) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_rx_valid", rx_valid, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cs", spi_cs_n, 2'b11);
      check("mid_rst_sck", spi_clk, 0);
      check("mid_rst_oe", spi_data_oe, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_tx_ready", tx_ready, 1);
      check("mid_rst_rx_valid", rx_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // TX underflow stalls between bytes with CS held
      loop_en = 1'b1;
      push_tx(8'h81);
      base = sck_cnt;
      burst(2, 1, 3'b001, 1'b0, 0);
      repeat (40) @(negedge clk);
      check("uf_stall_sck", sck_cnt - base, 8);
      check("uf_stall_clk", spi_clk, 0);
      check("uf_stall_cs", spi_cs_n, 2'b01);
      check("uf_stall_busy", busy, 1);
      push_tx(8'h42);
      push_tx(8'h18);
      wait_done("uf_done", 200);
      check("uf_sck", sck_cnt - base, 24);
      pop_rx("uf_rx0", 8'h81);
      pop_rx("uf_rx1", 8'h42);
      pop_rx("uf_rx2", 8'h18);

      // RX full stalls the burst; a start while busy is ignored
      loop_en = 1'b0;
      for (int i = 0; i < 4; i++) slave_tbl[i] = 4'b0010;
      base = sck_cnt;
      burst(5, 0, 3'b010, 1'b0, 0);
      repeat (60) @(negedge clk);
      check("rf_stall_sck", sck_cnt - base, 16);
      check("rf_stall_busy", busy, 1);
      check("rf_stall_clk", spi_clk, 0);
      check("rf_stall_cs", spi_cs_n, 2'b10);
      burst(0, 1, 3'b001, 1'b1, 0);
      check("rf_ignored_cs", spi_cs_n, 2'b10);
      dbase    = done_cnt;
      n        = 0;
      rx_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (rx_valid) begin
            check("rf_rx_data", rx_data, 8'hAA);
            n++;
         end
         if (done_cnt != dbase && !rx_valid) break;
         @(negedge clk);
      end
      rx_ready = 1'b0;
      check("rf_rx_count", n, 6);
      check("rf_sck", sck_cnt - base, 24);
      check("rf_done", done_cnt - dbase, 1);
      repeat (10) @(negedge clk);
      check("rf_idle_busy", busy, 0);
      check("rf_idle_cs", spi_cs_n, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
